pc_sequencer: RTL and testbench

//  Run-control sequencer for the program counter. Owns the PC's reset, start (enable),

---
 rtl/pc_sequencer_pkg.sv | 11 +
 rtl/pc_sequencer_if.sv | 29 ++
 rtl/pc_sequencer.sv | 66 ++++++
 tb/tb_pc_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_seq_pkg: shared types, default widths and offset sign-extension for the PC sequencer.
package pc_seq_pkg;
    localparam int SEQ_D     = 8;
    localparam int SEQ_OFF_W = 6;
    localparam int SEQ_CNT_W = 16;
    localparam logic [SEQ_D-1:0] HOLD_TARGET = '0;
    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DONE, RESTART} seq_state_t;
    function automatic logic [SEQ_D-1:0] sext_off(input logic [SEQ_OFF_W-1:0] off);
        return SEQ_D'($signed(off));
    endfunction
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decode requests in, PC control and status out.
interface pc_sequencer_if #(
    parameter int D     = 8,
    parameter int OFF_W = 6,
    parameter int CNT_W = 16
);
    logic             start;
    logic             halt_req;
    logic             stall;
    logic             branch_req;
    logic             branch_taken;
    logic [OFF_W-1:0] branch_offset;
    logic             pc_reset;
    logic             pc_enable;
    logic             pc_reljump_en;
    logic [D-1:0]     pc_target;
    logic             running;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;
    modport master (
        output start, halt_req, stall, branch_req, branch_taken, branch_offset,
        input  pc_reset, pc_enable, pc_reljump_en, pc_target, running, done, timeout, cycle_count
    );
    modport slave (
        input  start, halt_req, stall, branch_req, branch_taken, branch_offset,
        output pc_reset, pc_enable, pc_reljump_en, pc_target, running, done, timeout, cycle_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: run-control FSM driving PC reset/enable/relative jump, with cycle counter.
// Optional watchdog enabled by defining PC_SEQ_WATCHDOG_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int D          = SEQ_D,
    parameter int OFF_W      = SEQ_OFF_W,
    parameter int CNT_W      = SEQ_CNT_W,
    parameter int MAX_CYCLES = 1024
) (
    input logic            clk,
    input logic            reset,
    pc_sequencer_if.slave  bus
);
    if (MAX_CYCLES < 1 || OFF_W > D) begin : g_bad_cfg
        $error("pc_sequencer: invalid parameters");
    end
    seq_state_t state, nxt;
    logic [CNT_W-1:0] cnt;
    logic hold, jump, wd_hit;
    assign hold = bus.halt_req || bus.stall;
    assign jump = bus.branch_req && bus.branch_taken;
    assign bus.cycle_count = cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = bus.start ? LAUNCH : IDLE;
            LAUNCH:  nxt = RUN;
            RUN:     nxt = (bus.halt_req || wd_hit) ? DONE : RUN;
            DONE:    nxt = bus.start ? RESTART : DONE;
            RESTART: nxt = LAUNCH;
            default: nxt = IDLE;
        endcase
    end
    // Outside RUN the PC is told to add zero so it cannot drift.
    always_comb begin
        bus.pc_reset      = state == IDLE || state == RESTART;
        bus.pc_enable     = state == LAUNCH;
        bus.running       = state == RUN;
        bus.done          = state == DONE;
        bus.pc_reljump_en = state != RUN || hold || jump;
        bus.pc_target     = (state == RUN && !hold && jump) ? sext_off(bus.branch_offset) : HOLD_TARGET;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (state == LAUNCH) cnt <= '0;
        else if (state == RUN && cnt != '1) cnt <= cnt + 1'b1;
    end
`ifdef PC_SEQ_WATCHDOG_EN
    logic to_q;
    assign wd_hit = state == RUN && !bus.halt_req && cnt == CNT_W'(MAX_CYCLES - 1);
    assign bus.timeout = to_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) to_q <= 1'b0;
        else if (state == DONE && bus.start) to_q <= 1'b0;
        else if (wd_hit) to_q <= 1'b1;
    end
`else
    assign wd_hit = 1'b0;
    assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed + random run-control checks against a phase-level reference model,
// with a behavioural PC driven by the sequencer outputs.
module tb_pc_sequencer;
    localparam int MAXC = 16;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    pc_sequencer_if #(.D(8), .OFF_W(6), .CNT_W(16)) bus ();
    pc_sequencer #(.D(8), .OFF_W(6), .CNT_W(16), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );
    logic [7:0] pc;
    logic started;
    always_ff @(posedge clk) begin
        if (bus.pc_reset) begin
            pc <= 8'd0;
            started <= 1'b0;
        end else begin
            if (started) pc <= pc + (bus.pc_reljump_en ? bus.pc_target : 8'd1);
            if (bus.pc_enable) started <= 1'b1;
        end
    end
    int passed = 0, total = 0, fails = 0;
    // phase: 0 idle, 1 launch, 2 run, 3 done, 4 restart
    int ph, cnt;
    bit to, mst;
    logic [7:0] mpc;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic drive(input bit s, input bit h, input bit st, input bit b, input bit t, input logic [5:0] o);
        bus.start = s; bus.halt_req = h; bus.stall = st;
        bus.branch_req = b; bus.branch_taken = t; bus.branch_offset = o;
    endtask
    task automatic model_reset();
        ph = 0; cnt = 0; to = 0;
    endtask
    task automatic step();
        bit e_rj, wd;
        logic [7:0] e_tg;
        int o;
        #1;
        e_rj = 1'b1;
        e_tg = 8'd0;
        if (ph == 2 && !bus.halt_req && !bus.stall) begin
            if (bus.branch_req && bus.branch_taken) begin
                o = int'(bus.branch_offset);
                if (o >= 32) o -= 64;
                e_tg = 8'(o);
            end else e_rj = 1'b0;
        end
        chk("pc_reset", bus.pc_reset, ph == 0 || ph == 4);
        chk("pc_enable", bus.pc_enable, ph == 1);
        chk("running", bus.running, ph == 2);
        chk("done", bus.done, ph == 3);
        chk("reljump_en", bus.pc_reljump_en, e_rj);
        chk("target", bus.pc_target, e_tg);
        chk("cycle_count", bus.cycle_count, cnt);
        chk("timeout", bus.timeout, to);
        chk("pc", pc, mpc);
        @(posedge clk);
        if (ph == 0 || ph == 4) begin
            mpc = 8'd0; mst = 0;
        end else begin
            if (mst) mpc = mpc + (e_rj ? e_tg : 8'd1);
            if (ph == 1) mst = 1;
        end
        if (ph == 0) ph = bus.start ? 1 : 0;
        else if (ph == 1) begin cnt = 0; ph = 2; end
        else if (ph == 2) begin
`ifdef PC_SEQ_WATCHDOG_EN
            wd = cnt == MAXC - 1 && !bus.halt_req;
`else
            wd = 0;
`endif
            if (cnt < 65535) cnt++;
            if (bus.halt_req) ph = 3;
            else if (wd) begin ph = 3; to = 1; end
        end else if (ph == 3) begin
            if (bus.start) begin ph = 4; to = 0; end
        end else ph = 1;
        #1;
    endtask
    task automatic async_reset_check(input string tag);
        #3 reset = 1'b0;
        #1;
        chk({tag, "_pc_reset"}, bus.pc_reset, 1);
        chk({tag, "_running"}, bus.running, 0);
        chk({tag, "_count"}, bus.cycle_count, 0);
        chk({tag, "_timeout"}, bus.timeout, 0);
        model_reset();
        @(posedge clk);
        #1;
        mpc = 8'd0; mst = 0;
        reset = 1'b1;
    endtask
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        drive(0, 0, 0, 0, 0, 6'd0);
        model_reset();
        #1;
        chk("rst_pc_reset", bus.pc_reset, 1);
        chk("rst_pc_enable", bus.pc_enable, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_count", bus.cycle_count, 0);
        chk("rst_timeout", bus.timeout, 0);
        repeat (2) @(posedge clk);
        #1;
        mpc = 8'd0; mst = 0;
        reset = 1'b1;
        step(); step();
        drive(1, 0, 0, 0, 0, 6'd0); step();
        drive(0, 0, 0, 0, 0, 6'd0);
        chk("launch_enable", bus.pc_enable, 1);
        step();
        chk("pc_first_run", pc, 0);
        for (int i = 0; i < 20 && mpc != 8'd5; i++) step();
        chk("reach_pc5", pc, 5);
        drive(0, 0, 0, 1, 1, 6'b111101);
        #1 chk("branch_target_fd", bus.pc_target, 8'hFD);
        step();
        chk("branch_pc2", pc, 2);
        drive(0, 0, 0, 0, 0, 6'd0);
        repeat (3) step();
        drive(0, 0, 0, 1, 0, 6'b111101);
        #1 chk("not_taken_rj", bus.pc_reljump_en, 0);
        step();
        chk("not_taken_pc6", pc, 6);
        drive(0, 0, 1, 1, 1, 6'd3);
        #1 chk("stall_target", bus.pc_target, 0);
        step();
        chk("stall_pc6", pc, 6);
        drive(0, 0, 0, 1, 1, 6'd3); step();
        chk("branch_pc9", pc, 9);
        drive(0, 1, 0, 0, 0, 6'd0); step();
        drive(0, 0, 0, 1, 1, 6'd7);
        chk("halt_done", bus.done, 1);
        repeat (20) step();
        chk("halt_pc9", pc, 9);
        chk("halt_cnt", bus.cycle_count, 13);
        drive(1, 0, 0, 0, 0, 6'd0); step();
        drive(0, 0, 0, 0, 0, 6'd0);
        chk("restart_pc_reset", bus.pc_reset, 1);
        step();
        chk("restart_pc0", pc, 0);
        step();
        chk("relaunch_cnt0", bus.cycle_count, 0);
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(7) == 0, $urandom_range(19) == 0, $urandom_range(3) == 0,
                  $urandom_range(2) == 0, 1'($urandom), 6'($urandom));
            step();
        end
        drive(0, 0, 0, 0, 0, 6'd0);
        async_reset_check("arst1");
        step();
        drive(1, 0, 0, 0, 0, 6'd0); step();
        drive(0, 0, 0, 0, 0, 6'd0); step();
        for (int i = 0; i < MAXC; i++) step();
`ifdef PC_SEQ_WATCHDOG_EN
        chk("wd_done", bus.done, 1);
        chk("wd_timeout", bus.timeout, 1);
`else
        chk("nowd_running", bus.running, 1);
        chk("nowd_timeout", bus.timeout, 0);
`endif
        step(); step();
        async_reset_check("arst2");
        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
